line_tap121_filter: RTL and testbench

- Streaming horizontal 1-2-1 smoothing stage for 8-bit greyscale images.
- Reads an image of ROWS x COLS pixels, row-major, from a source synchronous RAM with 1-cycle registered read and output-enable.
- Applies a 3-tap [1 2 1]/4 kernel along each row, replicating the edge pixel at column boundaries.
- Writes results to a separate destination RAM at the same linear addresses. Sits between the source-image RAM and the destination-image RAM; a start/busy/done handshake sequences each frame.

---
 rtl/line_tap121_filter_pkg.sv | 26 ++
 rtl/line_tap121_filter_if.sv | 52 +++++
 rtl/line_tap121_filter_tap3_window.sv | 58 +++++
 rtl/line_tap121_filter.sv | 176 +++++++++++++++++
 tb/tb_line_tap121_filter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/line_tap121_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_tap121_filter_pkg
//  Purpose  : Shared types and constants for the horizontal 1-2-1 line filter.
//             Holds the frame FSM encoding, pixel and sum widths, the
//             rounding constants and the read-to-write pipeline latency.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package line_tap121_filter_pkg;

   localparam int PIX_W     = 8;    // greyscale pixel width
   localparam int SUM_W     = 10;   // l + 2c + r, max 1020
   localparam int RND_ADD   = 2;    // round-half-up offset before /4
   localparam int RND_SHIFT = 2;    // kernel normalisation (divide by 4)
   localparam int WR_LAT    = 4;    // address-present to write-strobe latency

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_GAP   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/line_tap121_filter_if.sv
`default_nettype none
// ============================================================================
//  Module   : line_tap121_filter_if
//  Purpose  : Frame handshake plus source/destination RAM bus of the filter.
//  Signals  : start/busy/done           frame handshake
//             src_addr/src_oe/src_rd_q  source RAM, 1-cycle registered read
//             dst_addr/dst_we/dst_wr_data destination RAM write port
//  Modports : master - the filter core
//             slave  - the surrounding system (controller + RAMs)
//  Revision : 1.0  initial release
// ============================================================================
interface line_tap121_filter_if #(
   parameter int ADDR_WIDTH = 8
);
   import line_tap121_filter_pkg::*;

   logic                  start;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic                  src_oe;
   logic [PIX_W-1:0]      src_rd_q;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic                  dst_we;
   logic [PIX_W-1:0]      dst_wr_data;

   modport master (
      input  start,
      input  src_rd_q,
      output busy,
      output done,
      output src_addr,
      output src_oe,
      output dst_addr,
      output dst_we,
      output dst_wr_data
   );

   modport slave (
      output start,
      output src_rd_q,
      input  busy,
      input  done,
      input  src_addr,
      input  src_oe,
      input  dst_addr,
      input  dst_we,
      input  dst_wr_data
   );

endinterface
`default_nettype wire

// File: rtl/line_tap121_filter_tap3_window.sv
`default_nettype none
// ============================================================================
//  Module   : line_tap121_filter_tap3_window
//  Purpose  : 3-entry pixel shift register (left/centre/right) with row-edge
//             replication.
//  Ports    : clk, rst_n        clock, async active-low reset
//             i_load            first pixel of a row: fill all taps with i_pix
//             i_shift           interior pixel: shift i_pix in on the right
//             i_rep             row end: shift, replicating the right tap
//             i_pix             incoming pixel
//             o_left/o_centre/o_right  current window
//  Revision : 1.0  initial release
// ============================================================================
module line_tap121_filter_tap3_window
   import line_tap121_filter_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_load,
   input  wire logic             i_shift,
   input  wire logic             i_rep,
   input  wire logic [PIX_W-1:0] i_pix,
   output logic      [PIX_W-1:0] o_left,
   output logic      [PIX_W-1:0] o_centre,
   output logic      [PIX_W-1:0] o_right
);

   logic [PIX_W-1:0] r_left;
   logic [PIX_W-1:0] r_centre;
   logic [PIX_W-1:0] r_right;

   // Loading all three taps on column 0 both replicates the left edge and
   // flushes the previous row, so no window ever spans two rows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_left   <= '0;
         r_centre <= '0;
         r_right  <= '0;
      end else if (i_load) begin
         r_left   <= i_pix;
         r_centre <= i_pix;
         r_right  <= i_pix;
      end else if (i_shift) begin
         r_left   <= r_centre;
         r_centre <= r_right;
         r_right  <= i_pix;
      end else if (i_rep) begin
         r_left   <= r_centre;
         r_centre <= r_right;
      end
   end

   assign o_left   = r_left;
   assign o_centre = r_centre;
   assign o_right  = r_right;

endmodule
`default_nettype wire

// File: rtl/line_tap121_filter.sv
`default_nettype none
// ============================================================================
//  Module   : line_tap121_filter
//  Purpose  : Streams a ROWS x COLS greyscale frame from a source RAM, applies
//             a [1 2 1]/4 horizontal kernel with edge replication and writes
//             the result to a destination RAM at the same linear address.
//  Ports    : clk    clock
//             rst_n  asynchronous active-low reset
//             bus    line_tap121_filter_if.master (handshake + RAM buses)
//  Revision : 1.0  initial release
// ============================================================================
module line_tap121_filter
   import line_tap121_filter_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int COLS       = 16,
   parameter int ROWS       = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   line_tap121_filter_if.master  bus
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROWS * COLS - 1);

   state_t                r_state;
   logic [COL_W-1:0]      r_col;
   logic [ROW_W-1:0]      r_row;
   logic                  r_rd_vld;    // src_rd_q carries valid data this cycle
   logic                  r_rd_first;  // ... and it is column 0
   logic                  r_rd_last;   // ... and it is column COLS-1
   logic                  r_edge;      // cycle after the last pixel of a row
   logic                  r_win_vld;   // window holds a complete output column
   logic [ADDR_WIDTH-1:0] r_wr_ptr;

   logic                  w_accept;
   logic                  w_last_wr;
   logic [PIX_W-1:0]      w_left;
   logic [PIX_W-1:0]      w_centre;
   logic [PIX_W-1:0]      w_right;
   logic [SUM_W-1:0]      w_sum;
   logic [SUM_W-1:0]      w_sum_rnd;
   logic [PIX_W-1:0]      w_pix;

   // A start landing on the done cycle is deliberately dropped.
   assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.done;
   assign w_last_wr = bus.dst_we && (bus.dst_addr == LAST_ADDR);

   // ------------------------------------------------------------------
   // Frame FSM and source address generation
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.src_oe   <= 1'b0;
         bus.src_addr <= '0;
      end else begin
         bus.done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state      <= ST_READ;
                  bus.busy     <= 1'b1;
                  bus.src_oe   <= 1'b1;
                  bus.src_addr <= '0;
                  r_col        <= '0;
                  r_row        <= '0;
               end
            end
            ST_READ: begin
               if (r_col == LAST_COL) begin
                  // Address holds through the gap; it advances on re-entry.
                  r_state    <= ST_GAP;
                  bus.src_oe <= 1'b0;
               end else begin
                  r_col        <= r_col + COL_W'(1);
                  bus.src_addr <= bus.src_addr + ADDR_WIDTH'(1);
               end
            end
            ST_GAP: begin
               if (r_row == LAST_ROW) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_state      <= ST_READ;
                  bus.src_oe   <= 1'b1;
                  bus.src_addr <= bus.src_addr + ADDR_WIDTH'(1);
                  r_col        <= '0;
                  r_row        <= r_row + ROW_W'(1);
               end
            end
            ST_DRAIN: begin
               if (w_last_wr) begin
                  r_state  <= ST_IDLE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read-data tracking: r_col describes the address presented this
   // cycle, so registering it aligns it with the returning data.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld   <= 1'b0;
         r_rd_first <= 1'b0;
         r_rd_last  <= 1'b0;
         r_edge     <= 1'b0;
         r_win_vld  <= 1'b0;
      end else begin
         r_rd_vld   <= bus.src_oe;
         r_rd_first <= (r_col == '0);
         r_rd_last  <= (r_col == LAST_COL);
         r_edge     <= r_rd_vld && r_rd_last;
         // Column 0 data alone cannot produce an output; every later
         // column yields the previous column, and the edge cycle yields
         // the last one.
         r_win_vld  <= (r_rd_vld && !r_rd_first) || r_edge;
      end
   end

   line_tap121_filter_tap3_window u_window (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (r_rd_vld && r_rd_first),
      .i_shift  (r_rd_vld && !r_rd_first),
      .i_rep    (r_edge),
      .i_pix    (bus.src_rd_q),
      .o_left   (w_left),
      .o_centre (w_centre),
      .o_right  (w_right)
   );

   // ------------------------------------------------------------------
   // Kernel: (l + 2c + r + 2) >> 2; max 1022 fits SUM_W, result fits PIX_W
   // ------------------------------------------------------------------
   assign w_sum     = SUM_W'(w_left) + (SUM_W'(w_centre) << 1) + SUM_W'(w_right);
   assign w_sum_rnd = w_sum + SUM_W'(RND_ADD);
   assign w_pix     = w_sum_rnd[SUM_W-1:RND_SHIFT];

   // ------------------------------------------------------------------
   // Destination write register; data and address hold while idle
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.dst_we      <= 1'b0;
         bus.dst_addr    <= '0;
         bus.dst_wr_data <= '0;
         r_wr_ptr        <= '0;
      end else begin
         bus.dst_we <= r_win_vld;
         if (w_accept) begin
            r_wr_ptr     <= '0;
            bus.dst_addr <= '0;
         end else if (r_win_vld) begin
            bus.dst_wr_data <= w_pix;
            bus.dst_addr    <= r_wr_ptr;
            r_wr_ptr        <= r_wr_ptr + ADDR_WIDTH'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_line_tap121_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_tap121_filter
//  Purpose  : Self-checking bench for line_tap121_filter. A source RAM model
//             returns garbage whenever the previous cycle had src_oe=0; every
//             write is compared against an image computed directly from the
//             kernel definition, and the handshake/timing schedule is checked
//             cycle by cycle relative to T0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_tap121_filter;

   localparam int C      = 16;
   localparam int R      = 16;
   localparam int N      = R * C;
   localparam int RW     = C + 1;                 // cycles per row incl. gap
   localparam int LAT    = 4;                     // address to write latency
   localparam int DONE_T = (R - 1) * RW + C + 4;  // done cycle relative to T0
   localparam int RUN_T  = DONE_T + 5;

   logic clk = 1'b0;
   logic rst_n;

   line_tap121_filter_if #(.ADDR_WIDTH(8)) bus ();

   line_tap121_filter #(.ADDR_WIDTH(8), .COLS(C), .ROWS(R)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- memories ----------------
   logic [7:0] src_mem [N];
   logic [7:0] dst_mem [N];
   int         exp_img [N];
   logic       rd_vld  = 1'b0;
   logic [7:0] rd_data = 8'h00;
   logic [7:0] garb    = 8'h00;

   // Invalid cycles return random junk so any illegal sample corrupts output.
   assign bus.src_rd_q = rd_vld ? rd_data : garb;

   always @(posedge clk) begin
      rd_vld  <= bus.src_oe;
      rd_data <= src_mem[bus.src_addr];
      garb    <= 8'($urandom);
      if (bus.dst_we) dst_mem[bus.dst_addr] <= bus.dst_wr_data;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference image: plain [1 2 1]/4 with edge replication, round half up.
   task automatic build_model();
      for (int i = 0; i < N; i++) begin
         int c, l, m, rr;
         c  = i % C;
         m  = int'(src_mem[i]);
         l  = (c == 0)     ? m : int'(src_mem[i-1]);
         rr = (c == C - 1) ? m : int'(src_mem[i+1]);
         exp_img[i] = (l + 2 * m + rr + 2) / 4;
      end
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       src_mem[i] = 8'h80;
            1:       src_mem[i] = 8'(10 * (i % C));
            2:       src_mem[i] = (i == 5)  ? 8'hFF : 8'h00;
            3:       src_mem[i] = (i == 15) ? 8'hFF : 8'h00;
            4:       src_mem[i] = 8'hFF;
            default: src_mem[i] = 8'($urandom);
         endcase
      end
      build_model();
   endtask

   // One frame. Checks the expected schedule every cycle from T0. start is
   // re-pulsed at repulse_t and also on the done cycle (both must be ignored).
   // If rst_t >= 0, reset is asserted at T0+rst_t for two cycles instead.
   task automatic run_frame(input int repulse_t, input int rst_t);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t < RUN_T; t++) begin
         int  rr, cc, k;
         logic exp_oe, exp_we;
         if (t == rst_t) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_busy",   32'(bus.busy),   0);
            check_eq("rst_src_oe", 32'(bus.src_oe), 0);
            check_eq("rst_dst_we", 32'(bus.dst_we), 0);
            check_eq("rst_done",   32'(bus.done),   0);
            check_eq("rst_src_addr", 32'(bus.src_addr), 0);
            check_eq("rst_dst_addr", 32'(bus.dst_addr), 0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               check_eq("post_rst_oe", 32'(bus.src_oe), 0);
               check_eq("post_rst_we", 32'(bus.dst_we), 0);
            end
            return;
         end
         rr     = t / RW;
         cc     = t % RW;
         exp_oe = (rr < R) && (cc < C);
         k      = t - LAT;
         exp_we = (k >= 0) && (k / RW < R) && (k % RW < C);
         check_eq($sformatf("busy t=%0d", t), 32'(bus.busy), 32'(t < DONE_T));
         check_eq($sformatf("done t=%0d", t), 32'(bus.done), 32'(t == DONE_T));
         check_eq($sformatf("src_oe t=%0d", t), 32'(bus.src_oe), 32'(exp_oe));
         if (exp_oe)
            check_eq($sformatf("src_addr t=%0d", t), 32'(bus.src_addr), 32'(rr * C + cc));
         check_eq($sformatf("dst_we t=%0d", t), 32'(bus.dst_we), 32'(exp_we));
         if (exp_we) begin
            int a;
            a = (k / RW) * C + (k % RW);
            check_eq($sformatf("dst_addr t=%0d", t), 32'(bus.dst_addr), 32'(a));
            check_eq($sformatf("dst_data a=%0d", a), 32'(bus.dst_wr_data), 32'(exp_img[a]));
         end
         bus.start = (t == repulse_t) || (t == DONE_T);
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check_eq("reset_busy",     32'(bus.busy),        0);
      check_eq("reset_done",     32'(bus.done),        0);
      check_eq("reset_src_oe",   32'(bus.src_oe),      0);
      check_eq("reset_src_addr", 32'(bus.src_addr),    0);
      check_eq("reset_dst_we",   32'(bus.dst_we),      0);
      check_eq("reset_dst_addr", 32'(bus.dst_addr),    0);
      check_eq("reset_dst_data", 32'(bus.dst_wr_data), 0);
      rst_n = 1'b1;

      // Constant frame with an ignored mid-frame start.
      fill(0);
      run_frame(10, -1);
      check_eq("const_a0",   32'(dst_mem[0]),   32'h80);
      check_eq("const_a255", 32'(dst_mem[255]), 32'h80);

      // Ramp row.
      fill(1);
      run_frame(-1, -1);
      check_eq("ramp_c0",     32'(dst_mem[0]),  32'h03);
      check_eq("ramp_c5",     32'(dst_mem[5]),  32'd50);
      check_eq("ramp_c15",    32'(dst_mem[15]), 32'h94);
      check_eq("ramp_r1_c15", 32'(dst_mem[31]), 32'h94);

      // Impulse.
      fill(2);
      run_frame(-1, -1);
      check_eq("imp_c4", 32'(dst_mem[4]), 32'h40);
      check_eq("imp_c5", 32'(dst_mem[5]), 32'h80);
      check_eq("imp_c6", 32'(dst_mem[6]), 32'h40);
      check_eq("imp_c7", 32'(dst_mem[7]), 32'h00);

      // Row-boundary isolation.
      fill(3);
      run_frame(-1, -1);
      check_eq("rowb_r0c14", 32'(dst_mem[14]), 32'h40);
      check_eq("rowb_r0c15", 32'(dst_mem[15]), 32'hBF);
      check_eq("rowb_r1c0",  32'(dst_mem[16]), 32'h00);

      // All 0xFF.
      fill(4);
      run_frame(-1, -1);
      check_eq("ff_a0",   32'(dst_mem[0]),   32'hFF);
      check_eq("ff_a255", 32'(dst_mem[255]), 32'hFF);

      // Random frames.
      for (int f = 0; f < 3; f++) begin
         fill(5);
         run_frame(-1, -1);
      end

      // Reset mid-frame, then a clean constant frame from address 0.
      fill(0);
      run_frame(-1, 7);
      run_frame(-1, -1);
      check_eq("rst_const_a0",   32'(dst_mem[0]),   32'h80);
      check_eq("rst_const_a255", 32'(dst_mem[255]), 32'h80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
